// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU controller: decodes one MIPS instruction, drives the ALU, captures the result two edges later.
// One instruction per 4 clocks best case; writeback holds stable under wb_ready backpressure, no new issue until it drains.
module alu_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic             instr_ready,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_csig,
  input  logic [31:0]      alu_out,
  input  logic             alu_z,
  input  logic             alu_n,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             wb_z,
  output logic             wb_n,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPT, S_WB} state_t;

  state_t           state_q, state_d;
  logic [31:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_csig_q, alu_csig_d;
  logic             wb_we_q, wb_we_d, wb_z_q, wb_z_d, wb_n_q, wb_n_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic        dec_legal, dec_we;
  logic [3:0]  dec_csig;
  logic [31:0] dec_a, dec_b, imm_sext, imm_zext;
  logic [4:0]  dec_rd;
  logic        accept;
  logic        unused_rs_field;

  // Source register indices come in pre-read as rs_data/rt_data.
  assign unused_rs_field = ^instr[25:21];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0000, instr[15:0]};

  always_comb begin
    dec_legal = 1'b0;
    dec_we    = 1'b1;
    dec_csig  = 4'b0000;
    dec_a     = rs_data;
    dec_b     = rt_data;
    dec_rd    = instr[20:16];
    if (instr[31:26] == 6'h00) begin
      dec_rd    = instr[15:11];
      dec_legal = 1'b1;
      case (instr[5:0])
        6'h20: dec_csig = 4'b0110;
        6'h22: dec_csig = 4'b0101;
        6'h24: dec_csig = 4'b0001;
        6'h25: dec_csig = 4'b0000;
        6'h26: dec_csig = 4'b0010;
        6'h27: dec_csig = 4'b0111;
        6'h2A: dec_csig = 4'b1001;
        6'h18: dec_csig = 4'b1010;
        6'h00, 6'h02, 6'h03: begin
          dec_a = rt_data;
          dec_b = {27'd0, instr[10:6]};
          dec_csig = (instr[5:0] == 6'h00) ? 4'b0011 :
                     (instr[5:0] == 6'h02) ? 4'b0100 : 4'b1110;
        end
        default: dec_legal = 1'b0;
      endcase
    end else begin
      dec_legal = 1'b1;
      case (instr[31:26])
        6'h08: begin dec_csig = 4'b0110; dec_b = imm_sext; end
        6'h0A: begin dec_csig = 4'b1001; dec_b = imm_sext; end
        6'h0C: begin dec_csig = 4'b0001; dec_b = imm_zext; end
        6'h0D: begin dec_csig = 4'b0000; dec_b = imm_zext; end
        6'h0E: begin dec_csig = 4'b0010; dec_b = imm_zext; end
        6'h23: begin dec_csig = 4'b1101; dec_b = imm_sext; end
        6'h2B: begin dec_csig = 4'b1101; dec_b = imm_sext; dec_we = 1'b0; end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && dec_legal) state_d = S_EXEC;
      S_EXEC:  state_d = S_CAPT;
      S_CAPT:  state_d = S_WB;
      S_WB:    if (wb_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == S_IDLE);
    wb_valid    = (state_q == S_WB);
  end

  always_comb begin
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_csig_d = alu_csig_q;
    wb_we_d    = wb_we_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_z_d     = wb_z_q;
    wb_n_d     = wb_n_q;
    retired_d  = retired_q;
    illegal_d  = accept && !dec_legal;
    if (accept && dec_legal) begin
      alu_a_d    = dec_a;
      alu_b_d    = dec_b;
      alu_csig_d = dec_csig;
      wb_rd_d    = dec_rd;
      wb_we_d    = dec_we && (dec_rd != 5'd0);
    end
    // ALU result is registered, so it is valid on the edge leaving CAPT.
    if (state_q == S_CAPT) begin
      wb_data_d = alu_out;
      wb_z_d    = alu_z;
      wb_n_d    = alu_n;
    end
    if (wb_valid && wb_ready) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_csig_q <= '0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_z_q     <= 1'b0;
      wb_n_q     <= 1'b0;
      illegal_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_csig_q <= alu_csig_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_z_q     <= wb_z_d;
      wb_n_q     <= wb_n_d;
      illegal_q  <= illegal_d;
      retired_q  <= retired_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_csig = alu_csig_q;
  assign wb_we    = wb_we_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign wb_z     = wb_z_q;
  assign wb_n     = wb_n_q;
  assign illegal  = illegal_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, stall/reset sequences, randomized traffic against a semantic model.
// The ALU itself is modelled here as a registered unit with one clock of latency.
module tb_alu_issue_ctrl;

  localparam int TB_CNT_W = 8;

  logic                clk, rst_n;
  logic                instr_valid, instr_ready;
  logic [31:0]         instr, rs_data, rt_data;
  logic [31:0]         alu_a, alu_b, alu_out;
  logic [3:0]          alu_csig;
  logic                alu_z, alu_n;
  logic                wb_valid, wb_ready, wb_we, wb_z, wb_n, illegal;
  logic [4:0]          wb_rd;
  logic [31:0]         wb_data;
  logic [TB_CNT_W-1:0] retired;

  alu_issue_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .instr_ready(instr_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_csig(alu_csig), .alu_out(alu_out),
    .alu_z(alu_z), .alu_n(alu_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_z(wb_z), .wb_n(wb_n),
    .illegal(illegal), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    case (c)
      4'b0110: return a + b;
      4'b0101: return a - b;
      4'b0001: return a & b;
      4'b0000: return a | b;
      4'b0010: return a ^ b;
      4'b0111: return ~(a | b);
      4'b1001: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1010: return a * b;
      4'b0011: return a << b[4:0];
      4'b0100: return a >> b[4:0];
      4'b1110: return $signed(a) >>> b[4:0];
      4'b1101: return (a + b) & ~32'd3;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_out <= alu_fn(alu_a, alu_b, alu_csig);
    alu_z   <= (alu_fn(alu_a, alu_b, alu_csig) == 32'd0);
    alu_n   <= ($signed(alu_a) < $signed(alu_b));
  end

  typedef struct {
    logic        legal;
    logic [3:0]  csig;
    logic [31:0] a, b;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        z, n;
  } exp_t;

  typedef struct {
    logic [31:0] instr, rs, rt;
    exp_t        e;
  } vec_t;

  int                  n_cmp = 0, n_bad = 0;
  logic [TB_CNT_W-1:0] exp_ret = '0;
  logic [31:0]         last_a = '0, last_b = '0;
  logic [3:0]          last_c = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected behaviour from instruction semantics, independent of the select encoding.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [31:0] si, zi;
    logic [4:0]  sh;
    si = {{16{ins[15]}}, ins[15:0]};
    zi = {16'h0, ins[15:0]};
    sh = ins[10:6];
    e = '{legal: 1'b1, csig: 4'h0, a: rs, b: rt, we: 1'b0, rd: ins[20:16], data: 32'h0, z: 1'b0, n: 1'b0};
    if (ins[31:26] == 6'h00) begin
      e.rd = ins[15:11];
      case (ins[5:0])
        6'h20: begin e.csig = 4'b0110; e.data = rs + rt; end
        6'h22: begin e.csig = 4'b0101; e.data = rs - rt; end
        6'h24: begin e.csig = 4'b0001; e.data = rs & rt; end
        6'h25: begin e.csig = 4'b0000; e.data = rs | rt; end
        6'h26: begin e.csig = 4'b0010; e.data = rs ^ rt; end
        6'h27: begin e.csig = 4'b0111; e.data = ~(rs | rt); end
        6'h2A: begin e.csig = 4'b1001; e.data = {31'd0, $signed(rs) < $signed(rt)}; end
        6'h18: begin e.csig = 4'b1010; e.data = rs * rt; end
        6'h00: begin e.csig = 4'b0011; e.a = rt; e.b = {27'd0, sh}; e.data = rt << sh; end
        6'h02: begin e.csig = 4'b0100; e.a = rt; e.b = {27'd0, sh}; e.data = rt >> sh; end
        6'h03: begin e.csig = 4'b1110; e.a = rt; e.b = {27'd0, sh}; e.data = $signed(rt) >>> sh; end
        default: e.legal = 1'b0;
      endcase
    end else begin
      case (ins[31:26])
        6'h08: begin e.csig = 4'b0110; e.b = si; e.data = rs + si; end
        6'h0A: begin e.csig = 4'b1001; e.b = si; e.data = {31'd0, $signed(rs) < $signed(si)}; end
        6'h0C: begin e.csig = 4'b0001; e.b = zi; e.data = rs & zi; end
        6'h0D: begin e.csig = 4'b0000; e.b = zi; e.data = rs | zi; end
        6'h0E: begin e.csig = 4'b0010; e.b = zi; e.data = rs ^ zi; end
        6'h23, 6'h2B: begin e.csig = 4'b1101; e.b = si; e.data = (rs + si) & ~32'd3; end
        default: e.legal = 1'b0;
      endcase
    end
    e.we = e.legal && (ins[31:26] != 6'h2B) && (e.rd != 5'd0);
    e.z  = (e.data == 32'd0);
    e.n  = ($signed(e.a) < $signed(e.b));
    return e;
  endfunction

  function automatic vec_t mk(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                              input logic lg, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic we, input logic [4:0] rd, input logic [31:0] d,
                              input logic z, input logic n);
    vec_t v;
    v.instr = i; v.rs = rs; v.rt = rt;
    v.e = '{legal: lg, csig: c, a: a, b: b, we: we, rd: rd, data: d, z: z, n: n};
    return v;
  endfunction

  // Entered and left at a negedge with the controller idle.
  task automatic do_instr(input string tag, input logic [31:0] ins, input logic [31:0] rs,
                          input logic [31:0] rt, input exp_t e, input int stall);
    chk({tag, ".ready"}, {31'd0, instr_ready}, 32'd1);
    instr = ins; rs_data = rs; rt_data = rt; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0; rs_data = $urandom(); rt_data = $urandom(); instr = $urandom();
    if (!e.legal) begin
      chk({tag, ".illegal"}, {31'd0, illegal}, 32'd1);
      chk({tag, ".ill_ready"}, {31'd0, instr_ready}, 32'd1);
      chk({tag, ".ill_a"}, alu_a, last_a);
      chk({tag, ".ill_b"}, alu_b, last_b);
      chk({tag, ".ill_csig"}, {28'd0, alu_csig}, {28'd0, last_c});
      @(negedge clk);
      chk({tag, ".ill_pulse"}, {31'd0, illegal}, 32'd0);
      chk({tag, ".ill_nowb"}, {31'd0, wb_valid}, 32'd0);
      chk({tag, ".ill_ret"}, 32'(retired), 32'(exp_ret));
      return;
    end
    chk({tag, ".exec_ready"}, {31'd0, instr_ready}, 32'd0);
    chk({tag, ".csig"}, {28'd0, alu_csig}, {28'd0, e.csig});
    chk({tag, ".a"}, alu_a, e.a);
    chk({tag, ".b"}, alu_b, e.b);
    @(negedge clk);
    chk({tag, ".capt_vld"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, ".capt_a"}, alu_a, e.a);
    chk({tag, ".capt_csig"}, {28'd0, alu_csig}, {28'd0, e.csig});
    @(negedge clk);
    wb_ready = (stall == 0);
    chk({tag, ".wb_vld"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, ".wb_ready_lo"}, {31'd0, instr_ready}, 32'd0);
    chk({tag, ".rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
    chk({tag, ".we"}, {31'd0, wb_we}, {31'd0, e.we});
    chk({tag, ".data"}, wb_data, e.data);
    chk({tag, ".zn"}, {30'd0, wb_z, wb_n}, {30'd0, e.z, e.n});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (i == stall - 1) wb_ready = 1'b1;
      chk({tag, ".stall_vld"}, {31'd0, wb_valid}, 32'd1);
      chk({tag, ".stall_ready"}, {31'd0, instr_ready}, 32'd0);
      chk({tag, ".stall_data"}, wb_data, e.data);
      chk({tag, ".stall_ctl"}, {24'd0, wb_rd, wb_we, wb_z, wb_n}, {24'd0, e.rd, e.we, e.z, e.n});
      chk({tag, ".stall_ret"}, 32'(retired), 32'(exp_ret));
    end
    @(negedge clk);
    exp_ret = exp_ret + 1'b1;
    last_a = e.a; last_b = e.b; last_c = e.csig;
    chk({tag, ".done_vld"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, ".done_ready"}, {31'd0, instr_ready}, 32'd1);
    chk({tag, ".retired"}, 32'(retired), 32'(exp_ret));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ready"}, {31'd0, instr_ready}, 32'd1);
    chk({tag, ".flags"}, {27'd0, wb_valid, illegal, wb_we, wb_z, wb_n}, 32'd0);
    chk({tag, ".rd"}, {27'd0, wb_rd}, 32'd0);
    chk({tag, ".data"}, wb_data, 32'd0);
    chk({tag, ".alu_ab"}, alu_a | alu_b, 32'd0);
    chk({tag, ".csig"}, {28'd0, alu_csig}, 32'd0);
    chk({tag, ".retired"}, 32'(retired), 32'd0);
  endtask

  logic [5:0] legal_ops [7]  = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
  logic [5:0] legal_fns [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h18, 6'h00, 6'h02, 6'h03};

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          r;
    w = $urandom();
    r = $urandom_range(0, 19);
    if (r < 9)       w[31:26] = legal_ops[$urandom_range(0, 6)];
    else if (r < 18) begin w[31:26] = 6'h00; w[5:0] = legal_fns[$urandom_range(0, 10)]; end
    return w;
  endfunction

  vec_t vecs [11];

  initial begin
    vecs[0]  = mk(32'h00221820, 32'd5, 32'd7, 1, 4'b0110, 32'd5, 32'd7, 1, 5'd3, 32'd12, 0, 1);
    vecs[1]  = mk(32'h00022100, 32'h0000DEAD, 32'h1, 1, 4'b0011, 32'h1, 32'd4, 1, 5'd4, 32'h10, 0, 1);
    vecs[2]  = mk(32'hAC22FFFF, 32'h100, 32'h55, 1, 4'b1101, 32'h100, 32'hFFFFFFFF, 0, 5'd2, 32'hFC, 0, 0);
    vecs[3]  = mk(32'hFC000000, 32'h1, 32'h2, 0, 4'b0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    vecs[4]  = mk(32'h00222822, 32'd3, 32'd5, 1, 4'b0101, 32'd3, 32'd5, 1, 5'd5, 32'hFFFFFFFE, 0, 1);
    vecs[5]  = mk(32'h20208000, 32'h10, 32'h0, 1, 4'b0110, 32'h10, 32'hFFFF8000, 0, 5'd0, 32'hFFFF8010, 0, 0);
    vecs[6]  = mk(32'h34278001, 32'h00F00000, 32'h0, 1, 4'b0000, 32'h00F00000, 32'h8001, 1, 5'd7, 32'h00F08001, 0, 0);
    vecs[7]  = mk(32'h00024843, 32'h0, 32'h80000000, 1, 4'b1110, 32'h80000000, 32'h1, 1, 5'd9, 32'hC0000000, 0, 1);
    vecs[8]  = mk(32'h0022183F, 32'h1, 32'h2, 0, 4'b0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    vecs[9]  = mk(32'h0022302A, 32'hFFFFFFFF, 32'h1, 1, 4'b1001, 32'hFFFFFFFF, 32'h1, 1, 5'd6, 32'h1, 0, 1);
    vecs[10] = mk(32'h00224026, 32'h1234, 32'h1234, 1, 4'b0010, 32'h1234, 32'h1234, 1, 5'd8, 32'h0, 1, 0);

    instr_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0; wb_ready = 1'b1;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #2 chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) do_instr($sformatf("vec%0d", i), vecs[i].instr, vecs[i].rs, vecs[i].rt, vecs[i].e, 0);

    do_instr("stall5", 32'h00221820, 32'd5, 32'd7, vecs[0].e, 5);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] w, a, b;
      w = rand_instr(); a = $urandom(); b = $urandom();
      do_instr($sformatf("rnd%0d", i), w, a, b, ref_model(w, a, b), $urandom_range(0, 3));
    end

    while (exp_ret != '1) begin
      logic [31:0] a, b;
      a = $urandom(); b = $urandom();
      do_instr("fill", 32'h00221820, a, b, ref_model(32'h00221820, a, b), 0);
    end
    chk("wrap_pre", 32'(retired), 32'((1 << TB_CNT_W) - 1));
    do_instr("wrap", 32'h00221820, 32'd1, 32'd2, ref_model(32'h00221820, 32'd1, 32'd2), 0);
    chk("wrap_zero", 32'(retired), 32'd0);

    do_instr("pre_rst", 32'h00221820, 32'd9, 32'd9, ref_model(32'h00221820, 32'd9, 32'd9), 0);
    instr = 32'h00221820; rs_data = 32'd5; rt_data = 32'd7; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("rst_exec_state", {31'd0, instr_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst_exec");
    exp_ret = '0; last_a = '0; last_b = '0; last_c = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_release_ready", {31'd0, instr_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_wb", {31'd0, wb_valid}, 32'd0);
    end
    do_instr("post_rst", 32'h00221820, 32'd5, 32'd7, vecs[0].e, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port instr_valid, input, 1: instruction offered.
REQ-005 SHALL have port instr, input, 32: MIPS instruction word.
REQ-006 SHALL have port rs_data, input, 32: rs register value, qualified by instr_valid.
REQ-007 SHALL have port rt_data, input, 32: rt register value, qualified by instr_valid.
REQ-008 SHALL have port instr_ready, output, 1: controller can accept an instruction.
REQ-009 SHALL have port alu_a, output, 32: ALU operand a.
REQ-010 SHALL have port alu_b, output, 32: ALU operand b.
REQ-011 SHALL have port alu_csig, output, 4: ALU operation select.
REQ-012 SHALL have port alu_out, input, 32: registered ALU result, one-clock latency.
REQ-013 SHALL have port alu_z, input, 1: ALU zero flag.
REQ-014 SHALL have port alu_n, input, 1: ALU less-than flag.
REQ-015 SHALL have port wb_valid, output, 1: writeback offered.
REQ-016 SHALL have port wb_ready, input, 1: writeback sink accepts.
REQ-017 SHALL have port wb_we, output, 1: register-file write enable.
REQ-018 SHALL have port wb_rd, output, 5: destination register.
REQ-019 SHALL have port wb_data, output, 32: result.
REQ-020 SHALL have port wb_z, output, 1: captured zero flag.
REQ-021 SHALL have port wb_n, output, 1: captured less-than flag.
REQ-022 SHALL have port illegal, output, 1: one-cycle pulse for an undecodable instruction.
REQ-023 SHALL have port retired, output, CNT_W: count of completed writeback handshakes.

Function
REQ-024 SHALL implement FSM IDLE -> EXEC -> CAPT -> WB -> IDLE; instr_ready=1 only in IDLE.
REQ-025 SHALL, on instr_valid&instr_ready at edge k, register alu_a, alu_b and alu_csig from decode and enter EXEC; alu_a/alu_b/alu_csig SHALL then hold stable through CAPT.
REQ-026 SHALL decode R-type (opcode 0) by funct: 20 ADD=0110, 22 SUB=0101, 24 AND=0001, 25 OR=0000, 26 XOR=0010, 27 NOR=0111, 2A SLT=1001, 18 MUL=1010, 00 SLL=0011, 02 SRL=0100, 03 SRA=1110; dest=rd.
REQ-027 SHALL use alu_a=rt_data and alu_b=zero-extended shamt for shifts; all other R-type use a=rs_data, b=rt_data.
REQ-028 SHALL decode I-type opcodes: 08 ADDI=0110 and 0A SLTI=1001 (sign-extended imm); 0C ANDI=0001, 0D ORI=0000, 0E XORI=0010 (zero-extended imm); 23 LW and 2B SW=1101 with b=sign-extended imm; a=rs_data; dest=rt.
REQ-029 SHALL drive wb_we=1 for all decoded instructions except SW (0), and SHALL force wb_we=0 when the destination is register 0.
REQ-030 SHALL treat any other opcode/funct as illegal: stay in IDLE, pulse illegal for exactly the cycle after edge k, produce no writeback, leave alu_* unchanged.
REQ-031 SHALL, in CAPT, sample alu_out into wb_data and alu_z/alu_n into wb_z/wb_n at edge k+2, and enter WB; wb_valid SHALL rise after edge k+2.
REQ-032 SHALL hold wb_valid, wb_we, wb_rd, wb_data, wb_z and wb_n stable while wb_valid&!wb_ready, for any number of cycles.
REQ-033 SHALL, on wb_valid&wb_ready, return to IDLE, clear wb_valid and increment retired modulo 2^CNT_W (wraps all-ones -> 0).
REQ-034 SHALL achieve best-case throughput of one instruction per 4 clocks; a new instruction SHALL be accepted no earlier than the edge after the writeback handshake.

Reset
REQ-035 SHALL, on rst_n low at any time, asynchronously force IDLE; wb_valid=0, illegal=0, wb_we=0, wb_rd=0, wb_data=0, wb_z=0, wb_n=0, alu_a=0, alu_b=0, alu_csig=0000, retired=0.
REQ-036 SHALL abort any in-flight instruction on reset without producing a writeback; instr_ready SHALL be 1 on the first edge after rst_n rises.

Verification
REQ-037 SHALL cover: ADD rd=3, rs_data=5, rt_data=7 -> alu_csig=0110 during EXEC; wb_valid after edge k+2 with wb_rd=3, wb_data=12, wb_we=1; retired=1.
REQ-038 SHALL cover: SLL rd=4, shamt=4, rt_data=0x1 -> alu_a=1, alu_b=4, wb_data=0x10.
REQ-039 SHALL cover: SW, rs_data=0x100, imm=0xFFFF -> alu_b=0xFFFFFFFF, wb_we=0, wb_data=0xFC.
REQ-040 SHALL cover: opcode 0x3F -> illegal high exactly 1 cycle; instr_ready stays 1; no wb_valid; retired unchanged.
REQ-041 SHALL cover: wb_ready held low 5 cycles -> wb_* stable for 5 cycles and instr_ready=0; retired increments once; back-to-back instructions accepted every 4 cycles with wb_ready=1; retired wraps at 0xFFFF -> 0.
REQ-042 SHALL cover: rst_n asserted in EXEC -> all outputs take reset values immediately; no wb_valid after release.
